// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic RV32I-subset instructions into 32-bit words
// and writes them sequentially into instruction memory from address 0.
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;

  logic [31:0] enc;
  logic        legal;
  logic        xfer;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (op)
      4'd0: enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd1: enc = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd2: enc = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      4'd3: enc = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      4'd4: enc = {imm[11:0], rs1, 3'b110, rd, 7'b0010011};
      4'd5: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      4'd6: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      4'd7: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: legal = 1'b0;
    endcase
  end

  // Ready depends only on state and control strobes, never on in_valid.
  assign in_ready = (state_q == S_RUN) && !start && !finish;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;

    if (xfer) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = enc;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = S_FULL;
          done_d  = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (start) begin
      state_d = S_RUN;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == S_RUN && finish) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2, DEPTH=4): directed steps
// followed by randomized traffic against a behavioural reference model.
`default_nettype none

module tb_instr_encoder;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk, rst, start, finish, in_valid, in_ready;
  logic [3:0]        op;
  logic [4:0]        rd, rs1, rs2;
  logic [12:0]       imm;
  logic              imem_we, err, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_run;
  int          m_cnt;
  bit          m_err, m_we, m_done;
  int unsigned m_addr, m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_enc(int o, int d, int s1, int s2, int im);
    int unsigned i12 = im % 4096;
    int unsigned r   = s2 * (1 << 20) + s1 * (1 << 15) + d * (1 << 7);
    case (o)
      0: return r + 51;
      1: return 32 * (1 << 25) + r + 51;
      2: return r + 7 * (1 << 12) + 51;
      3: return r + 6 * (1 << 12) + 51;
      4: return i12 * (1 << 20) + s1 * (1 << 15) + 6 * (1 << 12) + d * (1 << 7) + 19;
      5: return i12 * (1 << 20) + s1 * (1 << 15) + 2 * (1 << 12) + d * (1 << 7) + 3;
      6: return (i12 / 32) * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15)
                + 2 * (1 << 12) + (i12 % 32) * (1 << 7) + 35;
      7: return ((im / 4096) % 2) * 32'h8000_0000 + ((im / 32) % 64) * (1 << 25)
                + s2 * (1 << 20) + s1 * (1 << 15) + ((im / 2) % 16) * (1 << 8)
                + ((im / 2048) % 2) * (1 << 7) + 99;
      default: return 0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".we"},    {31'd0, imem_we}, {31'd0, m_we});
    chk({tag, ".addr"},  32'(imem_addr), m_addr);
    chk({tag, ".wdata"}, imem_wdata, m_wdata);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".err"},   {31'd0, err}, {31'd0, m_err});
    chk({tag, ".done"},  {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic cycle(input string tag, input bit st, input bit fin, input bit v,
                       input int o, input int d, input int s1, input int s2, input int im);
    bit exp_rdy, xfer;
    start = st; finish = fin; in_valid = v;
    op = 4'(o); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im);
    #1;
    exp_rdy = m_run && !st && !fin;
    chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    xfer = v && exp_rdy;
    m_we = 0; m_done = 0;
    if (xfer && o < 8) begin
      m_we    = 1;
      m_addr  = m_cnt;
      m_wdata = ref_enc(o, d, s1, s2, im % 8192);
      m_cnt++;
      if (m_cnt == DEPTH) begin m_run = 0; m_done = 1; end
    end else if (xfer) begin
      m_err = 1;
    end
    if (st) begin
      m_run = 1; m_cnt = 0; m_err = 0;
    end else if (fin && m_run) begin
      m_run = 0; m_done = 1;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1; start = 0; finish = 0; in_valid = 0;
    @(posedge clk); #1;
    m_run = 0; m_cnt = 0; m_err = 0; m_we = 0; m_done = 0; m_addr = 0; m_wdata = 0;
    check_outputs(tag);
    chk({tag, ".ready"}, {31'd0, in_ready}, 32'd0);
    rst = 0;
  endtask

  initial begin
    clk = 0; rst = 1; start = 0; finish = 0; in_valid = 0;
    op = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    @(posedge clk);
    reset_cycle("reset");

    // Single ADD x3,x1,x2
    cycle("start0", 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("add0", 0, 0, 1, 0, 3, 1, 2, 0);
    chk("add0.lit", imem_wdata, 32'h002081B3);

    // Back-to-back until full, then restart for the ORI
    cycle("start1", 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("sub", 0, 0, 1, 1, 5, 6, 7, 0);
    chk("sub.lit", imem_wdata, 32'h407302B3);
    cycle("lw", 0, 0, 1, 5, 4, 2, 0, 8);
    chk("lw.lit", imem_wdata, 32'h00812203);
    cycle("sw", 0, 0, 1, 6, 0, 1, 5, 12);
    chk("sw.lit", imem_wdata, 32'h0050A623);
    cycle("beq", 0, 0, 1, 7, 0, 1, 2, 8192 - 8);
    chk("beq.lit", imem_wdata, 32'hFE208CE3);
    chk("beq.done", {31'd0, done}, 32'd1);
    cycle("full_hold", 0, 0, 1, 0, 1, 1, 1, 0);
    cycle("start2", 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("ori", 0, 0, 1, 4, 1, 0, 0, 12'hFFF);
    chk("ori.lit", imem_wdata, 32'hFFF06093);
    chk("ori.addr", 32'(imem_addr), 32'd0);

    // Illegal op between two ADDs
    cycle("start3", 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("ill_add1", 0, 0, 1, 0, 1, 2, 3, 0);
    cycle("ill_op9", 0, 0, 1, 9, 4, 5, 6, 0);
    cycle("ill_add2", 0, 0, 1, 0, 7, 8, 9, 0);
    chk("ill.addr", 32'(imem_addr), 32'd1);
    chk("ill.count", 32'(count), 32'd2);
    chk("ill.err", {31'd0, err}, 32'd1);

    // Stream of 6 ADDs into a 4-deep memory
    cycle("start4", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("stream", 0, 0, 1, 0, i + 1, i, i + 2, 0);
    chk("stream.count", 32'(count), 32'(DEPTH));

    // finish with in_valid in RUN, then finish in IDLE
    cycle("start5", 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("fin_run", 0, 1, 1, 0, 1, 1, 1, 0);
    cycle("fin_idle", 0, 1, 0, 0, 0, 0, 0, 0);

    // rst right after a transfer
    cycle("start6", 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("pre_rst", 0, 0, 1, 2, 9, 10, 11, 0);
    cycle("pre_rst_ill", 0, 0, 1, 12, 0, 0, 0, 0);
    in_valid = 1; op = 0;
    reset_cycle("mid_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit st, fin;
      int o;
      st  = ($urandom_range(0, 15) == 0);
      fin = ($urandom_range(0, 19) == 0);
      o   = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      cycle("rand", st, fin, $urandom_range(0, 3) != 0, o,
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 8191));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Program-loader block for the RV32I-subset core. It is the encoder counterpart of the control decoder.
- Accepts symbolic instructions (op class plus register and immediate fields) over a valid/ready handshake.
- Encodes each one into a 32-bit RV32I word and writes it sequentially into instruction memory from address 0.
- Tracks the fill level, flags illegal op classes, and reports completion.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin new program: address/count to 0, error cleared
finish  in  1  end of program (accepted only in RUN)
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept fields this cycle
op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ORI, 5 LW, 6 SW, 7 BEQ, 8-15 illegal
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  13  immediate; I/S types use imm[11:0]; BEQ uses imm[12:1] as byte offset, imm[0] ignored
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address of write
imem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written since last start
err  out  1  sticky: illegal op received since start
done  out  1  one-cycle pulse on RUN->IDLE or RUN->FULL

Behaviour:
- Reset values: state IDLE; in_ready, imem_we, err, done = 0; imem_addr, imem_wdata, count = 0.
- States:
  - IDLE: start -> RUN.
  - RUN: finish -> IDLE with done. Final write (count reaches DEPTH) -> FULL with done.
  - FULL: start -> RUN.
- start in any state: addr = 0, count = 0, err = 0, next state RUN. start has priority over finish.
- start during RUN restarts; any write already registered still completes in the next cycle.
- in_ready = (state == RUN) and not start and not finish. Combinational from state, start, finish only; never from in_valid.
- Transfer occurs when in_valid && in_ready at edge N.
- For a legal op, in cycle N+1:
  - imem_we = 1, imem_addr = current write pointer, imem_wdata = encoded word.
  - Write pointer and count increment at that edge. Latency is exactly 1 cycle; throughput is 1 word/cycle.
- imem_we is high for exactly one cycle per legal transfer. imem_addr and imem_wdata hold their last values while imem_we = 0.
- Illegal op (8-15): transfer completes (consumed) but no write occurs. err is set at edge N+1; pointer and count are unchanged.
- Encodings (opcode[6:0], funct3, funct7):
  - ADD: {0000000, rs2, rs1, 000, rd, 0110011}
  - SUB: {0100000, rs2, rs1, 000, rd, 0110011}
  - AND: {0000000, rs2, rs1, 111, rd, 0110011}
  - OR: {0000000, rs2, rs1, 110, rd, 0110011}
  - ORI: {imm[11:0], rs1, 110, rd, 0010011}
  - LW: {imm[11:0], rs1, 010, rd, 0000011}
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}
  - Unused fields for a given type are ignored; they do not affect the encoding.
- Full boundary:
  - The transfer that will write address DEPTH-1 drops in_ready combinationally from the next cycle.
  - State becomes FULL in the same edge that the final write issues; count = DEPTH.
  - The pointer does not wrap.
- finish is sampled in RUN only. In IDLE or FULL it is ignored and done is not pulsed.
- rst mid-operation: pending write is dropped (imem_we = 0 next cycle) and all state returns to reset values.

Test Plan:
- start; op0 rd3 rs1=1 rs2=2 -> next cycle imem_we=1, addr 0, wdata 0x002081B3; count=1.
- Back-to-back: SUB x5,x6,x7; LW x4,8(x2); SW x5,12(x1); BEQ x1,x2,imm=-8; ORI x1,x0,imm=0xFFF -> consecutive cycles, addr 0-4, wdata 0x407302B3, 0x00812203, 0x0050A623, 0xFE208CE3, 0xFFF06093.
- op=9 between two ADDs -> no write for op 9, err=1, second ADD lands at addr 1, count=2; err held until next start.
- ADDR_W=2, stream 6 ADDs -> writes at addr 0-3, done pulse with final write, in_ready=0 thereafter, count=4, no wrap to addr 0; start -> in_ready=1 and next write at addr 0.
- finish with in_valid=1 in RUN -> no transfer, done pulse, state IDLE, in_ready=0; finish in IDLE -> no done.
- rst asserted in cycle after a transfer -> imem_we=0, count=0, err=0, in_ready=0.
